// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the sync_fifo push-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned burst_w(input int unsigned m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotate-priority encoder: first asserted req at or above start, wrapping modulo NUM_REQ.
module fifo_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   pick,
  output logic               any_req
);

  int unsigned      idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(start) + i) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        pick    = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing the sync_fifo push port between NUM_REQ producers.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]    req_data,
  input  logic                              fifo_full,
  output logic                              fifo_push,
  output logic [DATA_LENGTH-1:0]            fifo_data,
  output logic [NUM_REQ-1:0]                ack,
  output logic [req_idx_w(NUM_REQ)-1:0]     grant_id,
  output logic                              busy
);

  localparam int unsigned          REQ_IDX_W = req_idx_w(NUM_REQ);
  localparam int unsigned          BURST_W   = burst_w(MAX_BURST);
  localparam logic [REQ_IDX_W-1:0] LAST_IDX  = REQ_IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0]   LIMIT     = BURST_W'(MAX_BURST - 1);

  arb_state_t           state, state_nxt;
  logic [REQ_IDX_W-1:0] grant_nxt, last_winner, last_nxt;
  logic [REQ_IDX_W-1:0] base, start, pick;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;
  logic                 any_req, owner_req, rel;

  // One picker serves both idle arbitration and release re-arbitration:
  // while owning, last_winner tracks grant_id, so the owner is always scanned last.
  assign base  = (state == ARB_OWN) ? grant_id : last_winner;
  assign start = (base == LAST_IDX) ? '0 : base + 1'b1;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_pick (
    .req     (req),
    .start   (start),
    .pick    (pick),
    .any_req (any_req)
  );

  assign owner_req = req[grant_id];
  assign busy      = (state == ARB_OWN);
  assign fifo_push = busy & owner_req & ~fifo_full;
  assign fifo_data = req_data[grant_id*DATA_LENGTH +: DATA_LENGTH];
  assign ack       = NUM_REQ'(fifo_push) << grant_id;
  assign rel       = ~owner_req | (fifo_push & (burst_cnt == LIMIT));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_winner;
    burst_nxt = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_nxt = ARB_OWN;
          grant_nxt = pick;
          last_nxt  = pick;
          burst_nxt = '0;
        end
      end
      ARB_OWN: begin
        // A dropped owner req is absent from the vector, so any_req covers only the others.
        if (rel) begin
          burst_nxt = '0;
          if (any_req) begin
            grant_nxt = pick;
            last_nxt  = pick;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (fifo_push) begin
          burst_nxt = burst_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      grant_id    <= '0;
      burst_cnt   <= '0;
      last_winner <= LAST_IDX;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      burst_cnt   <= burst_nxt;
      last_winner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: directed producer scenarios, monitor checks every push.
module tb_fifo_push_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         push_seen = 0;
  int         left[4];
  logic [7:0] pdata[4];

  fifo_push_arbiter #(
    .NUM_REQ     (4),
    .DATA_LENGTH (8),
    .MAX_BURST   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted word must match the next expected (producer, data) pair.
  always @(negedge clk) begin
    if (fifo_push === 1'b1) begin
      if (q.size() == 0) begin
        check("mon_push_expected", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mon_grant_id", 32'(grant_id), 32'(e.id));
        check("mon_ack", 32'(ack), 32'(1) << e.id);
        check("mon_data", 32'(fifo_data), 32'(e.data));
      end
    end
  end

  function automatic void expect_words(input int id, input logic [7:0] d0, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = id;
      e.data = d0 + 8'(k);
      q.push_back(e);
    end
  endfunction

  function automatic void drive();
    for (int i = 0; i < 4; i++) begin
      req[i]            = (left[i] != 0);
      req_data[i*8 +: 8] = pdata[i];
    end
  endfunction

  // Producer model: a word is retired and the next one presented after each ack.
  task automatic tick();
    logic [3:0] a;
    @(negedge clk);
    a = ack;
    if (fifo_push === 1'b1) push_seen++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (a[i] && left[i] != 0) begin
        left[i]  = left[i] - 1;
        pdata[i] = pdata[i] + 8'd1;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i]  = 0;
      pdata[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (((left[0] + left[1] + left[2] + left[3]) != 0 || q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 32'(left[0] + left[1] + left[2] + left[3]), 32'd0);
    check("drain_queue", 32'(q.size()), 32'd0);
    q.delete();
    tick();
    tick();
    #2;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i]  = 0;
      pdata[i] = '0;
    end
    drive();
    #3;
    check("rst_push", 32'(fifo_push), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    do_reset();

    // 1: single producer, first push one cycle after the arbitration edge
    left[0] = 1; pdata[0] = 8'hA5; drive();
    expect_words(0, 8'hA5, 1);
    tick();
    #2;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd0);
    check("t1_push", 32'(fifo_push), 32'd1);
    check("t1_ack", 32'(ack), 32'b0001);
    check("t1_data", 32'(fifo_data), 32'hA5);
    drain(20);

    // 2: all four request, bursts of 4 rotate 0,1,2,3 with no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      left[i]  = 4;
      pdata[i] = 8'h10 * 8'(i + 1);
    end
    drive();
    for (int i = 0; i < 4; i++) expect_words(i, 8'h10 * 8'(i + 1), 4);
    tick();
    push_seen = 0;
    repeat (16) tick();
    check("t2_pushes_16_cycles", 32'(push_seen), 32'd16);
    drain(30);

    // 3: fifo_full stalls producer 2 mid-burst; owner and count are held
    do_reset();
    left[2] = 4; pdata[2] = 8'h50; drive();
    expect_words(2, 8'h50, 4);
    tick();
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("t3_full_push", 32'(fifo_push), 32'd0);
      check("t3_full_ack", 32'(ack), 32'd0);
      check("t3_full_grant", 32'(grant_id), 32'd2);
      tick();
    end
    fifo_full = 1'b0;
    push_seen = 0;
    repeat (3) tick();
    check("t3_remaining_words", 32'(push_seen), 32'd3);
    drain(20);

    // 4: sole requester is re-granted after each limit release, pushing every cycle
    do_reset();
    left[1] = 9; pdata[1] = 8'h60; drive();
    expect_words(1, 8'h60, 9);
    tick();
    push_seen = 0;
    repeat (9) tick();
    check("t4_pushes_9_cycles", 32'(push_seen), 32'd9);
    drain(20);

    // 5: owner 3 drops req after two words, producer 0 takes over next edge
    do_reset();
    left[3] = 2; pdata[3] = 8'h70; drive();
    expect_words(3, 8'h70, 2);
    expect_words(0, 8'h80, 2);
    tick();
    left[0] = 2; pdata[0] = 8'h80; drive();
    tick();
    tick();
    #2;
    check("t5_drop_push", 32'(fifo_push), 32'd0);
    check("t5_drop_grant", 32'(grant_id), 32'd3);
    tick();
    #2;
    check("t5_new_grant", 32'(grant_id), 32'd0);
    check("t5_new_busy", 32'(busy), 32'd1);
    check("t5_new_push", 32'(fifo_push), 32'd1);
    drain(20);

    // 6: asynchronous reset between edges kills the in-flight word
    do_reset();
    left[0] = 4; pdata[0] = 8'h90;
    left[1] = 4; pdata[1] = 8'hA0;
    drive();
    expect_words(0, 8'h90, 1);
    tick();
    tick();
    #2;
    check("t6_pre_push", 32'(fifo_push), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_push", 32'(fifo_push), 32'd0);
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_words(0, 8'h91, 3);
    expect_words(1, 8'hA0, 4);
    tick();
    #2;
    check("t6_grant_after_rst", 32'(grant_id), 32'd0);
    check("t6_busy_after_rst", 32'(busy), 32'd1);
    drain(30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
